seq_detect_prog: RTL and testbench

//   Programmable serial-pattern detector; successor to the fixed 1-bit sequence FSM in Lab_Practicals.

---
 rtl/seq_detect_prog.sv | 153 +++++++++++++++
 tb/tb_seq_detect_prog.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial pattern detector with per-bit
// don't-care mask, overlap select and a saturating match counter.
module seq_detect_prog #(
   parameter int                 PAT_LEN     = 4,
   parameter int                 CNT_W       = 8,
   parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1011,
   parameter logic               DEFAULT_OVL = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic [PAT_LEN-1:0] cfg_mask,
   input  logic               cfg_overlap,
   input  logic               bit_valid,
   input  logic               bit_in,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               cnt_sat,
   output logic               armed
);

   localparam int               FW      = $clog2(PAT_LEN + 1);
   localparam logic [FW-1:0]    LAST    = FW'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      FILL = 1'b0,
      HUNT = 1'b1
   } state_t;

   state_t             state;
   state_t             state_d;
   logic [PAT_LEN-1:0] pattern;
   logic [PAT_LEN-1:0] mask;
   logic               overlap;
   logic [PAT_LEN-1:0] hist;
   logic [PAT_LEN-1:0] hist_d;
   logic [PAT_LEN-1:0] next_hist;
   logic [FW-1:0]      fill;
   logic [FW-1:0]      fill_d;
   logic               take;
   logic               hit;
   logic               done;
   logic               match_ev;
   logic [CNT_W-1:0]   cnt_d;
   logic               sat_d;

   // Configuration registers: defaults at reset, reload on cfg_we.
   always_ff @(posedge clk) begin
      if (rst) begin
         pattern <= DEFAULT_PAT;
         mask    <= '1;
         overlap <= DEFAULT_OVL;
      end else if (cfg_we) begin
         pattern <= cfg_pattern;
         mask    <= cfg_mask;
         overlap <= cfg_overlap;
      end
   end

   // Candidate window and masked compare for the bit being sampled.
   always_comb begin
      next_hist = {hist[PAT_LEN-2:0], bit_in};
      hit       = (((next_hist ^ pattern) & mask) == '0);
      take      = bit_valid & ~cfg_we;
   end

   // State register with fill counter and history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
         fill  <= '0;
         hist  <= '0;
      end else begin
         state <= state_d;
         fill  <= fill_d;
         hist  <= hist_d;
      end
   end

   // Next-state: fill then hunt; a non-overlap hit restarts the fill.
   always_comb begin
      state_d = state;
      fill_d  = fill;
      hist_d  = hist;
      if (cfg_we) begin
         state_d = FILL;
         fill_d  = '0;
         hist_d  = '0;
      end else if (bit_valid) begin
         hist_d = next_hist;
         unique case (state)
            FILL: begin
               fill_d = fill + FW'(1);
               if (fill == LAST) begin
                  state_d = HUNT;
               end
            end
            HUNT: begin
               fill_d = fill;
            end
            default: begin
               state_d = FILL;
            end
         endcase
         if (match_ev && !overlap) begin
            state_d = FILL;
            fill_d  = '0;
            hist_d  = '0;
         end
      end
   end

   // Outputs: armed follows state; a match needs a full window.
   always_comb begin
      armed    = (state == HUNT);
      done     = armed | (fill == LAST);
      match_ev = take & done & hit;
   end

   // Counter next value: clear wins, otherwise saturating increment.
   always_comb begin
      cnt_d = match_count;
      sat_d = cnt_sat;
      if (cnt_clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (match_ev) begin
         if (match_count != CNT_MAX) begin
            cnt_d = match_count + CNT_W'(1);
         end
         if (cnt_d == CNT_MAX) begin
            sat_d = 1'b1;
         end
      end
   end

   // Registered match pulse and counter, updated with the sampling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         match       <= 1'b0;
         match_count <= '0;
         cnt_sat     <= 1'b0;
      end else begin
         match       <= match_ev;
         match_count <= cnt_d;
         cnt_sat     <= sat_d;
      end
   end

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed stimulus with a queue-based window model
// checked every cycle, plus literal expectations per scenario.
module tb_seq_detect_prog;

   localparam int P    = 4;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [P-1:0]  cfg_pattern;
   logic [P-1:0]  cfg_mask;
   logic          cfg_overlap;
   logic          bit_valid;
   logic          bit_in;
   logic          cnt_clr;
   logic          match;
   logic [CW-1:0] match_count;
   logic          cnt_sat;
   logic          armed;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_on = 1'b0;

   bit           mq[$];
   logic [P-1:0] m_pat = 4'b1011;
   logic [P-1:0] m_mask = 4'b1111;
   logic         m_ovl = 1'b1;
   logic         e_match = 1'b0;
   logic         e_sat = 1'b0;
   logic         e_armed = 1'b0;
   int           e_cnt = 0;

   seq_detect_prog #(
      .PAT_LEN(P),
      .CNT_W(CW),
      .DEFAULT_PAT(4'b1011),
      .DEFAULT_OVL(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern),
      .cfg_mask(cfg_mask),
      .cfg_overlap(cfg_overlap),
      .bit_valid(bit_valid),
      .bit_in(bit_in),
      .cnt_clr(cnt_clr),
      .match(match),
      .match_count(match_count),
      .cnt_sat(cnt_sat),
      .armed(armed)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Oldest bit in the window lines up with the pattern MSB.
   function automatic bit window_hit();
      for (int i = 0; i < P; i++) begin
         if (m_mask[P-1-i] && (mq[i] != m_pat[P-1-i])) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Reference model: window of the last P accepted bits.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_pat   = 4'b1011;
         m_mask  = 4'b1111;
         m_ovl   = 1'b1;
         e_match = 1'b0;
         e_cnt   = 0;
         e_sat   = 1'b0;
      end else begin
         e_match = 1'b0;
         if (cfg_we) begin
            m_pat  = cfg_pattern;
            m_mask = cfg_mask;
            m_ovl  = cfg_overlap;
            mq.delete();
         end else if (bit_valid) begin
            mq.push_back(bit_in);
            if (mq.size() > P) void'(mq.pop_front());
            if (mq.size() == P && window_hit()) begin
               e_match = 1'b1;
               if (!m_ovl) mq.delete();
            end
         end
         if (cnt_clr) begin
            e_cnt = 0;
            e_sat = 1'b0;
         end else if (e_match) begin
            if (e_cnt < CMAX) e_cnt++;
            if (e_cnt == CMAX) e_sat = 1'b1;
         end
      end
      e_armed = (mq.size() == P);
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         check("model_match", 32'(match), 32'(e_match));
         check("model_count", 32'(match_count), 32'(e_cnt));
         check("model_sat", 32'(cnt_sat), 32'(e_sat));
         check("model_armed", 32'(armed), 32'(e_armed));
      end
   end

   task automatic send(input logic b, input logic em, input int idle,
                       input logic clr);
      bit_valid = 1'b1;
      bit_in    = b;
      cnt_clr   = clr;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      cnt_clr   = 1'b0;
      check("match_lit", 32'(match), 32'(em));
      repeat (idle) begin
         @(posedge clk);
         #1;
         check("match_gap", 32'(match), 32'd0);
      end
   endtask

   task automatic send_str(input logic [15:0] bits, input logic [15:0] em,
                           input int n, input int idle);
      for (int i = 0; i < n; i++) begin
         send(bits[n-1-i], em[n-1-i], idle, 1'b0);
      end
   endtask

   task automatic cfg(input logic [P-1:0] p, input logic [P-1:0] m,
                      input logic o, input logic v, input logic b);
      cfg_we      = 1'b1;
      cfg_pattern = p;
      cfg_mask    = m;
      cfg_overlap = o;
      bit_valid   = v;
      bit_in      = b;
      @(posedge clk);
      #1;
      cfg_we    = 1'b0;
      bit_valid = 1'b0;
      check("cfg_match", 32'(match), 32'd0);
      check("cfg_armed", 32'(armed), 32'd0);
   endtask

   task automatic clr();
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      check("clr_count", 32'(match_count), 32'd0);
      check("clr_sat", 32'(cnt_sat), 32'd0);
   endtask

   task automatic reset_checks();
      check("rst_match", 32'(match), 32'd0);
      check("rst_count", 32'(match_count), 32'd0);
      check("rst_sat", 32'(cnt_sat), 32'd0);
      check("rst_armed", 32'(armed), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      cfg_we      = 1'b0;
      cfg_pattern = '0;
      cfg_mask    = '0;
      cfg_overlap = 1'b0;
      bit_valid   = 1'b0;
      bit_in      = 1'b0;
      cnt_clr     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_checks();
      chk_on = 1'b1;
      rst    = 1'b0;

      // Defaults, overlapping search
      send_str(16'b1011011, 16'b0001001, 7, 0);
      check("t1_count", 32'(match_count), 32'd2);

      // Non-overlapping search
      clr();
      cfg(4'b1011, 4'b1111, 1'b0, 1'b0, 1'b0);
      send_str(16'b1011, 16'b0001, 4, 0);
      check("t2_armed_b4", 32'(armed), 32'd0);
      send_str(16'b011, 16'b000, 3, 0);
      check("t2_armed_b7", 32'(armed), 32'd0);
      send_str(16'b0, 16'b0, 1, 0);
      check("t2_armed_b8", 32'(armed), 32'd1);
      check("t2_count", 32'(match_count), 32'd1);

      // Masked pattern with don't-care middle bits
      clr();
      cfg(4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0);
      send_str(16'b1001, 16'b0001, 4, 0);
      send_str(16'b1111, 16'b0001, 4, 0);
      check("t3_count", 32'(match_count), 32'd2);

      // Gaps between valid bits
      clr();
      cfg(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0);
      send_str(16'b1011, 16'b0001, 4, 3);
      check("t4_count", 32'(match_count), 32'd1);

      // Mask all zeros: every full-window bit hits; saturation then clear
      clr();
      cfg(4'b1011, 4'b0000, 1'b1, 1'b0, 1'b0);
      send_str(16'b10110110, 16'b00011111, 8, 0);
      check("t5_count_sat", 32'(match_count), 32'd3);
      check("t5_sat", 32'(cnt_sat), 32'd1);
      send(1'b1, 1'b1, 0, 1'b1);
      check("t5_clr_count", 32'(match_count), 32'd0);
      check("t5_clr_sat", 32'(cnt_sat), 32'd0);

      // Reset mid-fill
      cfg(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0);
      send_str(16'b10, 16'b00, 2, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      reset_checks();
      send_str(16'b101, 16'b000, 3, 0);
      check("t6_armed_b3", 32'(armed), 32'd0);
      send_str(16'b1, 16'b1, 1, 0);
      check("t6_count", 32'(match_count), 32'd1);

      // Bit presented with cfg_we is dropped
      cfg(4'b1011, 4'b1111, 1'b1, 1'b1, 1'b1);
      check("t6_cfg_count", 32'(match_count), 32'd1);
      send_str(16'b0110, 16'b0000, 4, 0);
      check("t6_armed_after", 32'(armed), 32'd1);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
